hbm_param_sequencer: RTL

Initiator side of the HBM parameter bus: accepts a stream of parameter commands from the instruction front-end over a valid/ready handshake and drives `params` plus exactly one of `input_param_id`/`weight_param_id`/`output_param_id` per cycle into `hbm_control`. It frames commands with `cmd_last`, rejects ids the register file does not decode, and reports completion with `cfg_done`. An optional shadow buffer replays the last good frame without re-fetching it.

---
 rtl/hbm_param_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/hbm_param_sequencer.sv
// hbm_param_sequencer: initiator side of the HBM parameter bus.
// Takes parameter command words over a valid/ready handshake, drops ids the
// register file cannot decode (raising a sticky err), and drives params plus
// one target id bus per cycle into hbm_control. A frame ends on cmd_last and
// completion is flagged with a one-cycle cfg_done pulse.
// Optional feature macro: HBM_PARAM_SEQ_SHADOW_EN adds a shadow buffer that
// can replay the last good frame when replay is pulsed in IDLE.
// Handshake: a word transfers on every rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_valid with cmd_ready low is held, not consumed.
module hbm_param_sequencer #(
    parameter int ADDR_WIDTH   = 33,
    parameter int SHADOW_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_target,
    input  logic [3:0]            cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_data,
    input  logic                  cmd_last,
    input  logic                  replay,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] params,
    output logic [3:0]            input_param_id,
    output logic [3:0]            weight_param_id,
    output logic [2:0]            output_param_id,
    output logic                  cfg_done,
    output logic                  busy,
    output logic                  err,
    output logic [7:0]            frame_words,
    output logic                  shadow_valid,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_REPLAY, ST_DONE} state_t;

    state_t                  state, state_d;
    logic                    accept, cmd_legal, frame_start, frame_end;
    logic                    replay_go, rp_last;
    logic                    iss_valid;
    logic [1:0]              iss_target;
    logic [3:0]              iss_id;
    logic [ADDR_WIDTH-1:0]   iss_data;
    logic [7:0]              fw_next;

    assign accept      = cmd_valid & cmd_ready;
    assign frame_start = accept & (state == ST_IDLE);
    assign frame_end   = accept & cmd_last;
    assign busy        = (state != ST_IDLE);
    assign dbg_state   = state;

    // Decode which ids the register file actually implements per target
    always_comb begin
        cmd_legal = 1'b0;
        case (cmd_target)
            2'd0:    cmd_legal = (cmd_id >= 4'd1) && (cmd_id <= 4'd11);
            2'd1:    cmd_legal = (cmd_id >= 4'd1) && (cmd_id <= 4'd8);
            2'd2:    cmd_legal = (cmd_id >= 4'd1) && (cmd_id <= 4'd4);
            default: cmd_legal = 1'b0;
        endcase
    end

`ifdef HBM_PARAM_SEQ_SHADOW_EN
    localparam int IDX_W = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
    localparam int LEN_W = IDX_W + 1;

    logic [ADDR_WIDTH+5:0] shadow_mem [SHADOW_DEPTH];
    logic [ADDR_WIDTH+5:0] rp_entry;
    logic [IDX_W-1:0]      rp_idx;
    logic [LEN_W-1:0]      shadow_len;
    logic [7:0]            wr_idx;
    logic                  shadow_wr;

    // A new command always beats a replay request in the same IDLE cycle
    assign replay_go = (state == ST_IDLE) & ~accept & replay & shadow_valid;
    assign wr_idx    = frame_start ? 8'd0 : frame_words;
    assign shadow_wr = accept & cmd_legal & (int'(wr_idx) < SHADOW_DEPTH);
    assign rp_entry  = shadow_mem[rp_idx];
    assign rp_last   = (({1'b0, rp_idx} + LEN_W'(1)) == shadow_len);

    // Capture legal words of the frame in flight; entries past the depth are dropped
    always_ff @(posedge clk) begin
        if (shadow_wr) shadow_mem[wr_idx[IDX_W-1:0]] <= {cmd_target, cmd_id, cmd_data};
    end

    // Replay pointer and shadow bookkeeping; a frame over the depth is not replayable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_idx       <= '0;
            shadow_len   <= '0;
            shadow_valid <= 1'b0;
        end else begin
            if (replay_go)               rp_idx <= '0;
            else if (state == ST_REPLAY) rp_idx <= rp_idx + IDX_W'(1);
            if (frame_end) begin
                shadow_valid <= (fw_next != 8'd0) && (int'(fw_next) <= SHADOW_DEPTH);
                shadow_len   <= fw_next[LEN_W-1:0];
            end else if (frame_start) begin
                shadow_valid <= 1'b0;
            end
        end
    end

    // Select the word to put on the bus: shadow entry during replay, else the command
    always_comb begin
        iss_valid  = accept & cmd_legal;
        iss_target = cmd_target;
        iss_id     = cmd_id;
        iss_data   = cmd_data;
        if (state == ST_REPLAY) begin
            iss_valid                      = 1'b1;
            {iss_target, iss_id, iss_data} = rp_entry;
        end
    end
`else
    logic unused_cfg;

    assign replay_go    = 1'b0;
    assign rp_last      = 1'b0;
    assign shadow_valid = 1'b0;
    assign unused_cfg   = replay & (SHADOW_DEPTH > 0);

    // Without the shadow buffer only accepted legal commands reach the bus
    always_comb begin
        iss_valid  = accept & cmd_legal;
        iss_target = cmd_target;
        iss_id     = cmd_id;
        iss_data   = cmd_data;
    end
`endif

    // Next state: frames start on the first accept, end on cmd_last, DONE lasts one cycle
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (accept)         state_d = cmd_last ? ST_DONE : ST_STREAM;
                else if (replay_go) state_d = ST_REPLAY;
            end
            ST_STREAM: if (frame_end) state_d = ST_DONE;
            ST_REPLAY: if (rp_last)   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Word count for the current frame: restarts on frame/replay start, saturates at 255
    always_comb begin
        fw_next = frame_words;
        if (frame_start)    fw_next = cmd_legal ? 8'd1 : 8'd0;
        else if (replay_go) fw_next = 8'd0;
        else if (iss_valid) fw_next = (frame_words == 8'hFF) ? 8'hFF : frame_words + 8'd1;
    end

    // Control registers; ready follows the upcoming state so it drops exactly in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            cfg_done    <= 1'b0;
            err         <= 1'b0;
            frame_words <= 8'd0;
        end else begin
            state       <= state_d;
            cmd_ready   <= (state_d == ST_IDLE) || (state_d == ST_STREAM);
            cfg_done    <= (state == ST_DONE);
            frame_words <= fw_next;
            if (accept && !cmd_legal) err <= 1'b1;
            else if (err_clr)         err <= 1'b0;
        end
    end

    // Bus register: id buses return to 0 on every cycle without a legal word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            params          <= '0;
            input_param_id  <= 4'd0;
            weight_param_id <= 4'd0;
            output_param_id <= 3'd0;
        end else begin
            input_param_id  <= 4'd0;
            weight_param_id <= 4'd0;
            output_param_id <= 3'd0;
            if (iss_valid) begin
                params <= iss_data;
                case (iss_target)
                    2'd0:    input_param_id  <= iss_id;
                    2'd1:    weight_param_id <= iss_id;
                    2'd2:    output_param_id <= iss_id[2:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
